// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry elastic pipeline register (main + skid) with flush,
// occupancy report and a saturating downstream-stall counter.
module pipe_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state, state_nx;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nx, skid_ctrl, skid_ctrl_nx;
    logic [DATA_W-1:0] main_data, main_data_nx, skid_data, skid_data_nx;
    logic              in_xfer, out_xfer;

    // Handshake outputs depend on registered state only.
    assign in_ready  = state != SKID;
    assign out_valid = state != EMPTY;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = state == SKID ? 2'd2 : state == FULL ? 2'd1 : 2'd0;

    always_comb begin
        state_nx     = state;
        main_ctrl_nx = main_ctrl;
        main_data_nx = main_data;
        skid_ctrl_nx = skid_ctrl;
        skid_data_nx = skid_data;
        if (flush) begin
            state_nx     = EMPTY;
            main_ctrl_nx = BUBBLE_CTRL;
            main_data_nx = '0;
            skid_ctrl_nx = '0;
            skid_data_nx = '0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    state_nx     = FULL;
                    main_ctrl_nx = in_ctrl;
                    main_data_nx = in_data;
                end
                FULL: if (in_xfer && out_xfer) begin
                    main_ctrl_nx = in_ctrl;
                    main_data_nx = in_data;
                end else if (in_xfer) begin
                    state_nx     = SKID;
                    skid_ctrl_nx = in_ctrl;
                    skid_data_nx = in_data;
                end else if (out_xfer) begin
                    state_nx     = EMPTY;
                    main_ctrl_nx = BUBBLE_CTRL;
                    main_data_nx = '0;
                end
                SKID: if (out_xfer) begin
                    state_nx     = FULL;
                    main_ctrl_nx = skid_ctrl;
                    main_data_nx = skid_data;
                    skid_ctrl_nx = '0;
                    skid_data_nx = '0;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nx;
            main_ctrl <= main_ctrl_nx;
            main_data <= main_data_nx;
            skid_ctrl <= skid_ctrl_nx;
            skid_data <= skid_data_nx;
        end
    end

    // Counts downstream backpressure regardless of flush; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomized checks of pipe_skid_reg against a
// queue-based reference model.
module tb_pipe_skid_reg;
    localparam logic [7:0] BUB = 8'hA5;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0]  out_ctrl, out_ctrl2;
    logic [31:0] out_data, out_data2;
    logic [1:0]  occupancy, occupancy2, stall2;
    logic [15:0] stall16;

    int errors = 0, checks = 0;

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(BUB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall16));

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(BUB), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
        .out_data(out_data2), .occupancy(occupancy2), .stall_cnt(stall2));

    always #5 clk = ~clk;

    typedef struct { logic [7:0] c; logic [31:0] d; } ent_t;
    ent_t        q[$];
    int unsigned st16 = 0, st2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of depth 2, updated on each clock edge.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            st16 = 0;
            st2  = 0;
        end else begin
            automatic bit ov = q.size() > 0;
            automatic bit ir = q.size() < 2;
            if (ov && !out_ready) begin
                if (st16 < 65535) st16++;
                if (st2 < 3) st2++;
            end
            if (flush) q.delete();
            else begin
                if (ov && out_ready) void'(q.pop_front());
                if (in_valid && ir) q.push_back('{in_ctrl, in_data});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        begin
            automatic bit ov = q.size() > 0;
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, ov);
            chk("out_ctrl", out_ctrl, ov ? q[0].c : BUB);
            chk("out_data", out_data, ov ? q[0].d : 32'h0);
            chk("occupancy", occupancy, q.size());
            chk("stall_cnt", stall16, st16);
            chk("stall_cnt2", stall2, st2);
            chk("out_data2", out_data2, ov ? q[0].d : 32'h0);
        end
    end

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] sat_exp [6];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, BUB);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall16, 0);
        rst = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            drive(1, 8'(i + 16), 32'(i), 1, 0);
            tick();
            chk("stream_data", out_data, i);
            chk("stream_valid", out_valid, 1);
            chk("stream_ready", in_ready, 1);
        end
        drive(0, 0, 0, 1, 0);
        tick();

        drive(1, 8'h01, 32'h11, 0, 0);
        tick();
        drive(1, 8'h02, 32'h22, 0, 0);
        tick();
        chk("bp_occ2", occupancy, 2);
        chk("bp_ready0", in_ready, 0);
        chk("bp_data_a", out_data, 32'h11);
        drive(0, 0, 0, 1, 0);
        tick();
        chk("bp_data_b", out_data, 32'h22);
        chk("bp_occ1", occupancy, 1);
        tick();
        chk("bp_occ0", occupancy, 0);

        drive(1, 8'h03, 32'h1, 0, 0);
        tick();
        drive(1, 8'h04, 32'h2, 0, 0);
        tick();
        drive(1, 8'h05, 32'h33, 0, 1);
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, BUB);
        chk("flush_data", out_data, 0);
        chk("flush_occ", occupancy, 0);
        drive(0, 0, 0, 1, 0);
        repeat (2) tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 8'h06, 32'h55, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("sat_stall", stall2, sat_exp[k]);
        end
        drive(0, 0, 0, 0, 1);
        tick();
        chk("sat_after_flush", stall2, 3);
        drive(0, 0, 0, 1, 0);
        tick();

        drive(1, 8'h07, 32'hA, 0, 0);
        tick();
        drive(1, 8'h08, 32'hB, 0, 0);
        tick();
        chk("ar_occ2", occupancy, 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_ctrl", out_ctrl, BUB);
        chk("ar_out_data", out_data, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_stall", stall16, 0);
        rst = 1'b0;
        drive(1, 8'h09, 32'h44, 1, 0);
        tick();
        chk("ar_data_44", out_data, 32'h44);
        chk("ar_valid_44", out_valid, 1);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(3) != 0, 8'($urandom), $urandom,
                  $urandom_range(9) < 7, $urandom_range(29) == 0);
            if ($urandom_range(499) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
